// File: rtl/mbldcm_pkg.sv
// Shared definitions for the mBldcm register map and the soft-start ramp master.
package mbldcm_pkg;

   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned RESP_W   = 2;
   localparam int unsigned CMP_W    = 17;
   localparam int unsigned PRSC_W   = 6;
   localparam int unsigned MAXCNT_W = 16;
   localparam int unsigned CNT_W    = 16;

   localparam logic [ADDR_W-1:0] ADDR_FREQ    = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_PWMCMP  = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_CONTROL = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_STATUS  = 2'd3;

   localparam logic [RESP_W-1:0] RESP_OK = 2'b00;

   localparam int unsigned CTRL_EN_BIT     = 0;
   localparam int unsigned CTRL_PHASE_LSB  = 2;
   localparam int unsigned CTRL_PFLAG_BIT  = 5;
   localparam int unsigned CTRL_PRSC_LSB   = 6;
   localparam int unsigned CTRL_MAXCNT_LSB = 12;

   localparam int unsigned STAT_REFL_BIT = 1;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_CMP, S_WR_CTRL, S_WR_FREQ, S_POLL,
      S_CHECK, S_DWELL, S_DONE, S_STOP
   } state_e;

   // Control word: phase fields and the phase-write flag are always left clear.
   function automatic logic [DATA_W-1:0] ctrl_word(input logic [MAXCNT_W-1:0] maxcnt,
                                                   input logic [PRSC_W-1:0]   prsc,
                                                   input logic                en);
      logic [DATA_W-1:0] w;
      w = '0;
      w[CTRL_EN_BIT]                  = en;
      w[CTRL_PHASE_LSB +: 3]          = 3'b000;
      w[CTRL_PFLAG_BIT]               = 1'b0;
      w[CTRL_PRSC_LSB +: PRSC_W]      = prsc;
      w[CTRL_MAXCNT_LSB +: MAXCNT_W]  = maxcnt;
      return w;
   endfunction

   // Next ramp point; clamps to the final value so the sum never wraps.
   function automatic logic [DATA_W-1:0] next_freq(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] fin,
                                                   input logic [DATA_W-1:0] step,
                                                   input logic              up);
      if (up)
         return ((step == '0) || ((fin - cur) <= step)) ? fin : cur + step;
      else
         return ((step == '0) || ((cur - fin) <= step)) ? fin : cur - step;
   endfunction

endpackage

// File: rtl/mbldcm_ramp_master_if.sv
// Avalon-MM bus between the ramp master and the mBldcm register slave.
interface mbldcm_ramp_master_if;
   logic [1:0]  oAddr;
   logic        oRead;
   logic        oWrite;
   logic [31:0] oWdata;
   logic [31:0] iRdata;
   logic        iWaitrequest;
   logic [1:0]  iResp;

   modport master (output oAddr, oRead, oWrite, oWdata,
                   input  iRdata, iWaitrequest, iResp);
   modport slave  (input  oAddr, oRead, oWrite, oWdata,
                   output iRdata, iWaitrequest, iResp);
endinterface

// File: rtl/mbldcm_avmm_xact.sv
// Single Avalon-MM transaction engine: launches on req_i, holds through waitrequest,
// pulses done_o with the captured read data and response.
module mbldcm_avmm_xact
   import mbldcm_pkg::*;
(
   input  logic                iClock,
   input  logic                iReset_n,
   input  logic                req_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic                wr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic                done_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic [RESP_W-1:0]   resp_o,
   mbldcm_ramp_master_if.master bus
);

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              rd_q;
   logic              wr_q;
   logic              done_q;
   logic [DATA_W-1:0] rdata_q;
   logic [RESP_W-1:0] resp_q;

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         done_q  <= 1'b0;
         rdata_q <= '0;
         resp_q  <= RESP_OK;
      end else begin
         done_q <= 1'b0;
         if (rd_q || wr_q) begin
            if (!bus.iWaitrequest) begin
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               done_q  <= 1'b1;
               rdata_q <= bus.iRdata;
               resp_q  <= bus.iResp;
            end
         end else if (req_i) begin
            addr_q  <= addr_i;
            wdata_q <= wr_i ? wdata_i : '0;
            wr_q    <= wr_i;
            rd_q    <= !wr_i;
         end
      end
   end

   assign bus.oAddr  = addr_q;
   assign bus.oWdata = wdata_q;
   assign bus.oRead  = rd_q;
   assign bus.oWrite = wr_q;
   assign done_o     = done_q;
   assign rdata_o    = rdata_q;
   assign resp_o     = resp_q;

endmodule

// File: rtl/mbldcm_ramp_master.sv
// Soft-start sequencer: programs PwmCmp and Control, then ramps FreqTarget
// step by step, polling Status until each step is reflected.
module mbldcm_ramp_master
   import mbldcm_pkg::*;
#(
   parameter int unsigned pPollLimit   = 1023,
   parameter int unsigned pDwellCycles = 0
)(
   input  logic                 iClock,
   input  logic                 iReset_n,
   mbldcm_ramp_master_if.master avm,
   input  logic                 iStart,
   input  logic                 iAbort,
   input  logic [DATA_W-1:0]    iFreqInit,
   input  logic [DATA_W-1:0]    iFreqFinal,
   input  logic [DATA_W-1:0]    iFreqStep,
   input  logic [CMP_W-1:0]     iPwmCmp,
   input  logic [PRSC_W-1:0]    iPwmPrsc,
   input  logic [MAXCNT_W-1:0]  iPwmMaxCnt,
   output logic                 oBusy,
   output logic                 oDone,
   output logic                 oError,
   output logic [DATA_W-1:0]    oFreqCur
);

   state_e              state_q;
   logic                req_q;
   logic [DATA_W-1:0]   final_q, step_q, cur_q, freq_cur_q;
   logic                up_q;
   logic [CMP_W-1:0]    cmp_q;
   logic [PRSC_W-1:0]   prsc_q;
   logic [MAXCNT_W-1:0] maxcnt_q;
   logic [CNT_W-1:0]    poll_cnt_q, dwell_cnt_q;
   logic                abort_q, fault_q, busy_q, done_q, error_q;

   logic                xact_done;
   logic [DATA_W-1:0]   xact_rdata;
   logic [RESP_W-1:0]   xact_resp;

   logic [ADDR_W-1:0]   req_addr_c;
   logic                req_wr_c;
   logic [DATA_W-1:0]   req_wdata_c;
   logic                abort_c, bus_state_c, bus_fault_c, poll_last_c, dwell_over_c;
   logic                unused_rdata_c;

   // Request fields follow the state; the engine latches them on req_q.
   always_comb begin
      req_addr_c  = ADDR_FREQ;
      req_wr_c    = 1'b1;
      req_wdata_c = cur_q;
      case (state_q)
         S_WR_CMP:  begin req_addr_c = ADDR_PWMCMP;  req_wdata_c = DATA_W'(cmp_q); end
         S_WR_CTRL: begin req_addr_c = ADDR_CONTROL; req_wdata_c = ctrl_word(maxcnt_q, prsc_q, 1'b1); end
         S_STOP:    begin req_addr_c = ADDR_CONTROL; req_wdata_c = ctrl_word(maxcnt_q, prsc_q, 1'b0); end
         S_POLL:    begin req_addr_c = ADDR_STATUS;  req_wr_c = 1'b0; req_wdata_c = '0; end
         default:   ;
      endcase
   end

   assign abort_c      = abort_q || iAbort;
   assign bus_state_c  = (state_q == S_WR_CMP) || (state_q == S_WR_CTRL) ||
                         (state_q == S_WR_FREQ) || (state_q == S_POLL);
   assign bus_fault_c  = (xact_resp != RESP_OK);
   assign poll_last_c  = ((17'(poll_cnt_q) + 17'd1) >= 17'(pPollLimit));
   assign dwell_over_c = (dwell_cnt_q >= CNT_W'(pDwellCycles));
   assign unused_rdata_c = ^{xact_rdata[DATA_W-1:STAT_REFL_BIT+1], xact_rdata[STAT_REFL_BIT-1:0]};

   mbldcm_avmm_xact u_xact (
      .iClock   (iClock),
      .iReset_n (iReset_n),
      .req_i    (req_q),
      .addr_i   (req_addr_c),
      .wr_i     (req_wr_c),
      .wdata_i  (req_wdata_c),
      .done_o   (xact_done),
      .rdata_o  (xact_rdata),
      .resp_o   (xact_resp),
      .bus      (avm)
   );

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         state_q     <= S_IDLE;
         req_q       <= 1'b0;
         final_q     <= '0;
         step_q      <= '0;
         cur_q       <= '0;
         freq_cur_q  <= '0;
         up_q        <= 1'b0;
         cmp_q       <= '0;
         prsc_q      <= '0;
         maxcnt_q    <= '0;
         poll_cnt_q  <= '0;
         dwell_cnt_q <= '0;
         abort_q     <= 1'b0;
         fault_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         abort_q <= (state_q != S_IDLE) && abort_c;
         // Bad response or pending abort diverts any completed access to STOP.
         if (bus_state_c && xact_done && (bus_fault_c || abort_c)) begin
            fault_q <= bus_fault_c;
            req_q   <= 1'b1;
            state_q <= S_STOP;
            if (state_q == S_WR_FREQ) freq_cur_q <= cur_q;
         end else begin
            case (state_q)
               S_IDLE: if (iStart && !iAbort) begin
                  final_q  <= iFreqFinal;
                  step_q   <= iFreqStep;
                  cur_q    <= iFreqInit;
                  up_q     <= (iFreqFinal >= iFreqInit);
                  cmp_q    <= iPwmCmp;
                  prsc_q   <= iPwmPrsc;
                  maxcnt_q <= iPwmMaxCnt;
                  fault_q  <= 1'b0;
                  busy_q   <= 1'b1;
                  req_q    <= 1'b1;
                  state_q  <= S_WR_CMP;
               end
               S_WR_CMP: if (xact_done) begin
                  req_q   <= 1'b1;
                  state_q <= S_WR_CTRL;
               end
               S_WR_CTRL: if (xact_done) begin
                  poll_cnt_q <= '0;
                  req_q      <= 1'b1;
                  state_q    <= S_WR_FREQ;
               end
               S_WR_FREQ: if (xact_done) begin
                  freq_cur_q <= cur_q;
                  req_q      <= 1'b1;
                  state_q    <= S_POLL;
               end
               S_POLL: if (xact_done) begin
                  if (xact_rdata[STAT_REFL_BIT]) begin
                     state_q <= S_CHECK;
                  end else if (poll_last_c) begin
                     fault_q <= 1'b1;
                     req_q   <= 1'b1;
                     state_q <= S_STOP;
                  end else begin
                     poll_cnt_q <= poll_cnt_q + CNT_W'(1);
                     req_q      <= 1'b1;
                  end
               end
               S_CHECK: begin
                  if (abort_c) begin
                     req_q   <= 1'b1;
                     state_q <= S_STOP;
                  end else if (cur_q == final_q) begin
                     state_q <= S_DONE;
                  end else begin
                     dwell_cnt_q <= '0;
                     state_q     <= S_DWELL;
                  end
               end
               S_DWELL: begin
                  if (abort_c) begin
                     req_q   <= 1'b1;
                     state_q <= S_STOP;
                  end else if (dwell_over_c) begin
                     cur_q      <= next_freq(cur_q, final_q, step_q, up_q);
                     poll_cnt_q <= '0;
                     req_q      <= 1'b1;
                     state_q    <= S_WR_FREQ;
                  end else begin
                     dwell_cnt_q <= dwell_cnt_q + CNT_W'(1);
                  end
               end
               S_DONE: begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               S_STOP: if (xact_done) begin
                  error_q <= fault_q;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign oBusy    = busy_q;
   assign oDone    = done_q;
   assign oError   = error_q;
   assign oFreqCur = freq_cur_q;

endmodule

// File: tb/tb_mbldcm_ramp_master.sv
// Directed bench for mbldcm_ramp_master with a small mBldcm slave model and bus log.
module tb_mbldcm_ramp_master;

   typedef struct packed {
      logic [1:0]  addr;
      logic        wr;
      logic [31:0] wdata;
      logic [7:0]  len;
      logic        stable;
   } xact_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iStart, iAbort;
   logic [31:0] iFreqInit, iFreqFinal, iFreqStep;
   logic [16:0] iPwmCmp;
   logic [5:0]  iPwmPrsc;
   logic [15:0] iPwmMaxCnt;
   logic        oBusy, oDone, oError;
   logic [31:0] oFreqCur;

   // slave model state (written only by the negedge monitor)
   logic        wait_r = 1'b0;
   logic [31:0] rdata_r = '0;
   logic [1:0]  resp_r = 2'b00;
   int          hold = 0;
   logic [1:0]  f_addr;
   logic        f_wr;
   logic [31:0] f_wd;
   logic        stab;
   xact_t       log_q [0:127];
   int          n_log = 0;
   int          done_cnt = 0, err_cnt = 0;
   logic        rw_both = 1'b0, de_both = 1'b0;

   // slave behaviour knobs (written only by the stimulus block)
   logic        stall_en = 1'b0, refl_en = 1'b1, err_en = 1'b0;

   int n_vec = 0;
   int n_mis = 0;

   mbldcm_ramp_master_if bus ();

   assign bus.iRdata       = rdata_r;
   assign bus.iWaitrequest = wait_r;
   assign bus.iResp        = resp_r;

   mbldcm_ramp_master #(.pPollLimit(4), .pDwellCycles(1)) dut (
      .iClock     (clk),
      .iReset_n   (rst_n),
      .avm        (bus),
      .iStart     (iStart),
      .iAbort     (iAbort),
      .iFreqInit  (iFreqInit),
      .iFreqFinal (iFreqFinal),
      .iFreqStep  (iFreqStep),
      .iPwmCmp    (iPwmCmp),
      .iPwmPrsc   (iPwmPrsc),
      .iPwmMaxCnt (iPwmMaxCnt),
      .oBusy      (oBusy),
      .oDone      (oDone),
      .oError     (oError),
      .oFreqCur   (oFreqCur)
   );

   always #5 clk = ~clk;

   // Slave model and bus log: decides waitrequest/rdata/resp for the next edge.
   always @(negedge clk) begin
      if (bus.oRead || bus.oWrite) begin
         if (hold == 0) begin
            f_addr = bus.oAddr; f_wr = bus.oWrite; f_wd = bus.oWdata; stab = 1'b1;
         end else if (bus.oAddr !== f_addr || bus.oWrite !== f_wr || bus.oWdata !== f_wd) begin
            stab = 1'b0;
         end
         hold    = hold + 1;
         wait_r  = stall_en && bus.oWrite && (bus.oAddr == 2'd2) && (hold <= 3);
         rdata_r = {30'd0, refl_en, 1'b0};
         resp_r  = (err_en && bus.oWrite && bus.oAddr == 2'd1) ? 2'b10 : 2'b00;
         if (!wait_r && n_log < 128) begin
            log_q[n_log] = '{addr: bus.oAddr, wr: bus.oWrite,
                             wdata: bus.oWrite ? bus.oWdata : 32'd0,
                             len: 8'(hold), stable: stab};
            n_log = n_log + 1;
         end
      end else begin
         hold = 0; wait_r = 1'b0; rdata_r = '0; resp_r = 2'b00;
      end
      if (bus.oRead && bus.oWrite) rw_both = 1'b1;
      if (oDone)  done_cnt = done_cnt + 1;
      if (oError) err_cnt  = err_cnt + 1;
      if (oDone && oError) de_both = 1'b1;
   end

   function automatic logic [34:0] xw(input logic [1:0] a, input logic [31:0] d);
      return {a, 1'b1, d};
   endfunction

   function automatic logic [34:0] xr(input logic [1:0] a);
      return {a, 1'b0, 32'd0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_log(input string tag, input int base, input logic [34:0] exp_q[$]);
      check({tag, "_count"}, 64'(n_log - base), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && base + i < n_log; i++)
         check($sformatf("%s[%0d]", tag, i),
               {log_q[base+i].addr, log_q[base+i].wr, log_q[base+i].wdata}, exp_q[i]);
   endtask

   task automatic start(input logic [31:0] init, input logic [31:0] fin, input logic [31:0] step);
      iFreqInit = init; iFreqFinal = fin; iFreqStep = step;
      iStart = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      check("busy_after_start", 64'(oBusy), 64'd1);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (oBusy && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 64'(oBusy), 64'd0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int base, d0, e0, n;
      logic [34:0] exp_q[$];

      rst_n = 1'b0; iStart = 1'b0; iAbort = 1'b0;
      iFreqInit = '0; iFreqFinal = '0; iFreqStep = '0;
      iPwmCmp = 17'h01234; iPwmPrsc = 6'd3; iPwmMaxCnt = 16'h0FFF;
      repeat (3) @(negedge clk);
      check("rst_read",    64'(bus.oRead),  64'd0);
      check("rst_write",   64'(bus.oWrite), 64'd0);
      check("rst_addr",    64'(bus.oAddr),  64'd0);
      check("rst_wdata",   64'(bus.oWdata), 64'd0);
      check("rst_busy",    64'(oBusy),      64'd0);
      check("rst_done",    64'(oDone),      64'd0);
      check("rst_error",   64'(oError),     64'd0);
      check("rst_freqcur", 64'(oFreqCur),   64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // up ramp 100 -> 400 step 100
      base = n_log; d0 = done_cnt; e0 = err_cnt;
      start(32'd100, 32'd400, 32'd100);
      wait_idle("up");
      exp_q = '{xw(2'd1, 32'h00001234), xw(2'd2, 32'h00FFF0C1),
                xw(2'd0, 32'd100), xr(2'd3), xw(2'd0, 32'd200), xr(2'd3),
                xw(2'd0, 32'd300), xr(2'd3), xw(2'd0, 32'd400), xr(2'd3)};
      check_log("up", base, exp_q);
      check("up_done",    64'(done_cnt - d0), 64'd1);
      check("up_error",   64'(err_cnt - e0),  64'd0);
      check("up_freqcur", 64'(oFreqCur),      64'd400);

      // down ramp 500 -> 120 step 200
      base = n_log; d0 = done_cnt; e0 = err_cnt;
      start(32'd500, 32'd120, 32'd200);
      wait_idle("down");
      exp_q = '{xw(2'd1, 32'h00001234), xw(2'd2, 32'h00FFF0C1),
                xw(2'd0, 32'd500), xr(2'd3), xw(2'd0, 32'd300), xr(2'd3),
                xw(2'd0, 32'd120), xr(2'd3)};
      check_log("down", base, exp_q);
      check("down_done",    64'(done_cnt - d0), 64'd1);
      check("down_freqcur", 64'(oFreqCur),      64'd120);

      // waitrequest stall on the Control write; init == final gives one FreqTarget write
      stall_en = 1'b1;
      base = n_log; d0 = done_cnt;
      start(32'd50, 32'd50, 32'd10);
      wait_idle("stall");
      stall_en = 1'b0;
      exp_q = '{xw(2'd1, 32'h00001234), xw(2'd2, 32'h00FFF0C1),
                xw(2'd0, 32'd50), xr(2'd3)};
      check_log("stall", base, exp_q);
      check("stall_len",    64'(log_q[base+1].len),    64'd4);
      check("stall_stable", 64'(log_q[base+1].stable), 64'd1);
      check("stall_done",   64'(done_cnt - d0),        64'd1);

      // poll timeout after 4 unreflected reads
      refl_en = 1'b0;
      base = n_log; d0 = done_cnt; e0 = err_cnt;
      start(32'd10, 32'd20, 32'd5);
      wait_idle("poll_to");
      refl_en = 1'b1;
      exp_q = '{xw(2'd1, 32'h00001234), xw(2'd2, 32'h00FFF0C1), xw(2'd0, 32'd10),
                xr(2'd3), xr(2'd3), xr(2'd3), xr(2'd3), xw(2'd2, 32'h00FFF0C0)};
      check_log("poll_to", base, exp_q);
      check("poll_to_error", 64'(err_cnt - e0),  64'd1);
      check("poll_to_done",  64'(done_cnt - d0), 64'd0);

      // bad response on the PwmCmp write
      err_en = 1'b1;
      base = n_log; d0 = done_cnt; e0 = err_cnt;
      start(32'd100, 32'd400, 32'd100);
      wait_idle("resp");
      err_en = 1'b0;
      exp_q = '{xw(2'd1, 32'h00001234), xw(2'd2, 32'h00FFF0C0)};
      check_log("resp", base, exp_q);
      check("resp_error", 64'(err_cnt - e0),  64'd1);
      check("resp_done",  64'(done_cnt - d0), 64'd0);

      // abort while polling the 200 step
      base = n_log; d0 = done_cnt; e0 = err_cnt;
      start(32'd100, 32'd400, 32'd100);
      n = 0;
      while (!(bus.oRead && bus.oAddr == 2'd3 && (n_log - base) >= 5) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("abort_reach_poll", 64'(n < 2000), 64'd1);
      iAbort = 1'b1;
      @(negedge clk);
      iAbort = 1'b0;
      wait_idle("abort");
      exp_q = '{xw(2'd1, 32'h00001234), xw(2'd2, 32'h00FFF0C1),
                xw(2'd0, 32'd100), xr(2'd3), xw(2'd0, 32'd200), xr(2'd3),
                xw(2'd2, 32'h00FFF0C0)};
      check_log("abort", base, exp_q);
      check("abort_done",    64'(done_cnt - d0), 64'd0);
      check("abort_error",   64'(err_cnt - e0),  64'd0);
      check("abort_freqcur", 64'(oFreqCur),      64'd200);

      // start together with abort in IDLE is ignored
      base = n_log;
      iStart = 1'b1; iAbort = 1'b1;
      @(negedge clk);
      iStart = 1'b0; iAbort = 1'b0;
      check("idle_abort_busy", 64'(oBusy), 64'd0);
      repeat (5) @(negedge clk);
      check("idle_abort_nobus", 64'(n_log - base), 64'd0);

      check("never_rd_and_wr",      64'(rw_both), 64'd0);
      check("never_done_and_error", 64'(de_both), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
